// File: rtl/mdu_if.sv
// Request/result bus of mult_div_unit.
// MDU_MTHILO_EN adds the mthi/mtlo/wdata HI/LO write port.
interface mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MDU_MTHILO_EN
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;

  modport master (
    output start, op, In1, In2, mthi, mtlo, wdata,
    input  busy, done, div_by_zero, hi, lo
  );
  modport slave (
    input  start, op, In1, In2, mthi, mtlo, wdata,
    output busy, done, div_by_zero, hi, lo
  );
`else
  modport master (
    output start, op, In1, In2,
    input  busy, done, div_by_zero, hi, lo
  );
  modport slave (
    input  start, op, In1, In2,
    output busy, done, div_by_zero, hi, lo
  );
`endif
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO registers, one result bit per cycle.
// Optional MDU_MTHILO_EN adds direct HI/LO writes (mthi/mtlo/wdata).
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state_q;
  logic             busy_q, done_q, dz_flag_q;
  logic             dz_op_q, is_div_q, neg_res_q, neg_rem_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] b_q, acc_hi_q, acc_lo_q, hi_q, lo_q;

  logic             is_signed;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot, rem;

  // op[0] clear selects the signed variants (MULT, DIV)
  assign is_signed = ~bus.op[0];
  assign mag1 = (is_signed && bus.In1[WIDTH-1]) ? -bus.In1 : bus.In1;
  assign mag2 = (is_signed && bus.In2[WIDTH-1]) ? -bus.In2 : bus.In2;

  // Multiply: acc_hi:acc_lo holds partial product over the remaining multiplier bits
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);

  // Divide: acc_hi is the remainder, acc_lo shifts dividend bits out and quotient bits in
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_diff  = div_shift[WIDTH-1:0] - b_q;

  assign prod = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
  assign quot = dz_op_q ? '1 : (neg_res_q ? -acc_lo_q : acc_lo_q);
  assign rem  = neg_rem_q ? -acc_hi_q : acc_hi_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_flag_q <= 1'b0;
      dz_op_q   <= 1'b0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      b_q       <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // busy is still high in the done cycle, so that cycle only releases it
          if (!busy_q && bus.start) begin
            busy_q    <= 1'b1;
            dz_flag_q <= 1'b0;
            state_q   <= StRun;
            cnt_q     <= CntW'(WIDTH - 1);
            is_div_q  <= bus.op[1];
            neg_res_q <= is_signed & (bus.In1[WIDTH-1] ^ bus.In2[WIDTH-1]);
            neg_rem_q <= is_signed & bus.In1[WIDTH-1];
            dz_op_q   <= bus.op[1] && (bus.In2 == '0);
            acc_hi_q  <= '0;
            if (bus.op[1]) begin
              acc_lo_q <= mag1;
              b_q      <= mag2;
            end else begin
              acc_lo_q <= mag2;
              b_q      <= mag1;
            end
          end else begin
            busy_q <= 1'b0;
          end
`ifdef MDU_MTHILO_EN
          if (!busy_q) begin
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
          end
`endif
        end
        StRun: begin
          if (is_div_q) begin
            if (div_ge) {acc_hi_q, acc_lo_q} <= {div_diff, acc_lo_q[WIDTH-2:0], 1'b1};
            else        {acc_hi_q, acc_lo_q} <= {div_shift[WIDTH-1:0], acc_lo_q[WIDTH-2:0], 1'b0};
          end else begin
            {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[WIDTH-1:1]};
          end
          if (cnt_q == '0) state_q <= StFix;
          else             cnt_q   <= cnt_q - CntW'(1);
        end
        StFix: begin
          if (is_div_q) begin
            hi_q      <= rem;
            lo_q      <= quot;
            dz_flag_q <= dz_op_q;
          end else begin
            {hi_q, lo_q} <= prod;
          end
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_flag_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: reference results queued at start, compared on done.
module tb_mult_div_unit;
  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(WIDTH)) bus ();

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb;
    int          q, r;
    e = '0;
    case (op)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = a;
          e.dz = 1'b1;
        end else if (op == 2'b11) begin
          e.lo = a / b;
          e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000;
          e.hi = 32'd0;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          e.lo = q;
          e.hi = r;
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("hi", 64'(bus.hi), 64'(mon_e.hi));
        check("lo", 64'(bus.lo), 64'(mon_e.lo));
        check("div_by_zero", 64'(bus.div_by_zero), 64'(mon_e.dz));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
    if (bus.busy) check("idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  // Start one op; poke also fires extra starts mid-run and in the done cycle
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    int          busy_cnt, done_at;
    logic [31:0] hi0;
    wait_idle();
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.In1   = a;
    bus.In2   = b;
    exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.In1   = $urandom;
    bus.In2   = $urandom;
    check("busy_on_accept", 64'(bus.busy), 64'd1);
    check("dz_cleared_on_accept", 64'(bus.div_by_zero), 64'd0);
    hi0      = bus.hi;
    busy_cnt = 1;
    done_at  = 0;
    for (int k = 1; k <= 100; k++) begin
      if (poke) bus.start = (k == 10) || (done_at != 0);
      @(posedge clk);
      #1;
      if (k == WIDTH) check("hi_held_during_run", 64'(bus.hi), 64'(hi0));
      if (bus.done && done_at == 0) done_at = k;
      if (bus.busy) busy_cnt++;
      else break;
    end
    bus.start = 1'b0;
    check("done_latency", 64'(done_at), 64'(WIDTH + 1));
    check("busy_length", 64'(busy_cnt), 64'(WIDTH + 2));
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.In1   = '0;
    bus.In2   = '0;
`ifdef MDU_MTHILO_EN
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_dz", 64'(bus.div_by_zero), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b11, 32'd100, 32'd0, 1'b0);
    run_op(2'b01, 32'd6, 32'd7, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'hFFFF_FFEC, 32'd0, 1'b0);
    run_op(2'b00, 32'd12345, 32'hFFFF_FF00, 1'b1);
    repeat (3) @(negedge clk);
    check("poke_no_restart", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(2'($urandom_range(0, 3)), $urandom,
             (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom, 1'b0);
    end

    // Asynchronous reset mid-run, away from any edge
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    wait_idle();
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.In1   = 32'hDEAD_BEEF;
    bus.In2   = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_done", 64'(bus.done), 64'd0);
    check("async_rst_hi", 64'(bus.hi), 64'd0);
    check("async_rst_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b01, 32'd6, 32'd7, 1'b0);

`ifdef MDU_MTHILO_EN
    wait_idle();
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.In1   = 32'hFFFF_FFFF;
    bus.In2   = 32'd2;
    exp_q.push_back(model(2'b01, 32'hFFFF_FFFF, 32'd2));
    @(negedge clk);
    bus.start = 1'b0;
    bus.mthi  = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.mthi  = 1'b0;
    wait_idle();
    @(negedge clk);
    check("mthi_ignored_busy", 64'(bus.hi), 64'd1);
    bus.mthi  = 1'b1;
    @(negedge clk);
    bus.mthi  = 1'b0;
    check("mthi_idle_hi", 64'(bus.hi), 64'h1234);
    check("mthi_idle_lo", 64'(bus.lo), 64'hFFFF_FFFE);
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h0000_5678;
    @(negedge clk);
    bus.mtlo  = 1'b0;
    check("mtlo_idle_lo", 64'(bus.lo), 64'h5678);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
